// File: rtl/irq_pkg.sv
// irq_arbiter shared types and register map.
// FSM encoding and config address constants.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_st_t;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_STAT = 2'd2;
  localparam logic [1:0] IRQ_SOFT = 2'd3;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Lowest-index-first priority encoder.
// Index 0 wins over all others.
module prio_enc #(
  parameter int N = 8,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // scan high to low so the lowest set bit is the last write
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter for the beta core.
// Edge-detected sources, mask/pend regs, one in-service id.
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             sv_bit,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata
);

  import irq_pkg::*;

  irq_st_t          st;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] wd;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] id_oh;
  logic [N_SRC-1:0] pend_set;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] cand;
  logic             cand_vld;
  logic [ID_W-1:0]  cand_idx;
  logic             ack_ok;
  logic             req_live;
  logic             we_mask;
  logic             we_pend;
  logic             we_soft;
  logic [4:0]       id5;

  assign wd      = cfg_wdata[N_SRC-1:0];
  assign rise    = src & ~src_q;
  assign id_oh   = N_SRC'(1) << irq_id;
  assign cand    = pend & mask;
  assign irq     = (st == REQ) & ~sv_bit;
  assign ack_ok  = irq_ack & irq;
  assign req_live = |(cand & id_oh);

  assign we_mask = cfg_we & (cfg_addr == IRQ_MASK);
  assign we_pend = cfg_we & (cfg_addr == IRQ_PEND);
  assign we_soft = cfg_we & (cfg_addr == IRQ_SOFT);

  generate
    if (N_SRC < 32) begin : g_wd_unused
      logic wdata_unused;
      assign wdata_unused = ^cfg_wdata[31:N_SRC];
    end
  endgenerate

  prio_enc #(
    .N (N_SRC),
    .W (ID_W)
  ) u_enc (
    .req   (cand),
    .valid (cand_vld),
    .idx   (cand_idx)
  );

  // set/clear terms for PEND; set is applied last so it wins
  always_comb begin
    pend_set = rise;
    pend_clr = '0;
    if (we_soft) pend_set = pend_set | wd;
    if (we_pend) pend_clr = pend_clr | wd;
    if (ack_ok)  pend_clr = pend_clr | id_oh;
  end

  // previous src; loads during reset so held lines give no edge
  always_ff @(posedge clk) begin
    src_q <= src;
  end

  // PEND and MASK registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (we_mask) mask <= wd;
    end
  end

  // request / service FSM; id frozen once requested
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      irq_id <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (cand_vld) begin
            irq_id <= cand_idx;
            st     <= REQ;
          end
        end
        REQ: begin
          if (ack_ok)         st <= SVC;
          else if (!req_live) st <= IDLE;
        end
        SVC: begin
          if (eret) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign id5 = 5'(irq_id);

  // register read mux
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      IRQ_MASK: cfg_rdata = 32'(mask);
      IRQ_PEND: cfg_rdata = 32'(pend);
      IRQ_STAT: cfg_rdata = {23'd0, id5, 2'b00, st};
      IRQ_SOFT: cfg_rdata = '0;
      default:  cfg_rdata = '0;
    endcase
  end

endmodule
